// File: rtl/imem_boot_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_boot_pkg
// Shared types and helpers for the instruction-memory boot loader.
//   boot_state_e       : controller state (RUN, LEN, DATA, SUM, ERR)
//   LEN_ZERO_MEANS_256 : a length byte of 0 announces a full 256-byte image
//   twos_neg8()        : checksum rule; the trailer byte must equal -sum mod 256
//   frame_len()        : converts the length byte into a remaining-byte count
// -----------------------------------------------------------------------------
package imem_boot_pkg;

   typedef enum logic [2:0] {
      ST_RUN  = 3'd0,
      ST_LEN  = 3'd1,
      ST_DATA = 3'd2,
      ST_SUM  = 3'd3,
      ST_ERR  = 3'd4
   } boot_state_e;

   localparam logic LEN_ZERO_MEANS_256 = 1'b1;

   // Two's complement negation; a frame is valid when sum + trailer == 0 mod 256.
   function automatic logic [7:0] twos_neg8(input logic [7:0] v);
      return (~v) + 8'd1;
   endfunction

   // Nine bits so that a full 256-byte image can be counted down.
   function automatic logic [8:0] frame_len(input logic [7:0] len_byte);
      if (LEN_ZERO_MEANS_256 && (len_byte == 8'd0)) begin
         return 9'd256;
      end
      return {1'b0, len_byte};
   endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// -----------------------------------------------------------------------------
// imem_boot_loader_if
// Groups the byte stream from the UART receiver and the instruction-memory
// port driven by the boot loader.
//   rx_valid / rx_data / rx_ready : byte stream into the loader
//   mem_addr / mem_w_data / mem_w_en : instruction-memory port
// Handshake: a byte moves on a rising clock edge where rx_valid && rx_ready
// are both high; the source keeps rx_data stable while rx_valid is high and
// the byte has not yet been taken. rx_ready does not depend on rx_valid.
// Modports: master = loader side, slave = stream source / memory side.
// -----------------------------------------------------------------------------
interface imem_boot_loader_if;

   logic       rx_valid;
   logic [7:0] rx_data;
   logic       rx_ready;
   logic [7:0] mem_addr;
   logic [7:0] mem_w_data;
   logic       mem_w_en;

   modport master (
      input  rx_valid,
      input  rx_data,
      output rx_ready,
      output mem_addr,
      output mem_w_data,
      output mem_w_en
   );

   modport slave (
      output rx_valid,
      output rx_data,
      input  rx_ready,
      input  mem_addr,
      input  mem_w_data,
      input  mem_w_en
   );

endinterface

// File: rtl/imem_boot_loader_timeout.sv
// -----------------------------------------------------------------------------
// imem_boot_timeout
// Idle-cycle counter used to abort a stalled load.
//   clock    : system clock
//   reset    : synchronous, active-high
//   i_en     : counting allowed (loader is in a busy state)
//   i_clr    : restart the idle count (byte accepted)
//   o_expire : this cycle is the TIMEOUT-th consecutive idle cycle
// With TIMEOUT == 0 the counter never advances and o_expire stays low.
// -----------------------------------------------------------------------------
module imem_boot_timeout #(
   parameter logic [15:0] TIMEOUT = 16'd0
) (
   input  logic clock,
   input  logic reset,
   input  logic i_en,
   input  logic i_clr,
   output logic o_expire
);

   localparam logic        ENABLED = (TIMEOUT != 16'd0);
   // The count shows completed idle cycles, so the TIMEOUT-th idle cycle is
   // the one that starts with the count at TIMEOUT-1.
   localparam logic [15:0] LIMIT   = ENABLED ? (TIMEOUT - 16'd1) : 16'd0;

   logic [15:0] r_count;

   assign o_expire = ENABLED && i_en && !i_clr && (r_count == LIMIT);

   always_ff @(posedge clock) begin
      if (reset || !i_en || i_clr || o_expire) begin
         r_count <= 16'd0;
      end else if (ENABLED) begin
         r_count <= r_count + 16'd1;
      end
   end

endmodule

// File: rtl/imem_boot_loader.sv
// -----------------------------------------------------------------------------
// imem_boot_loader
// Shares the 8-bit instruction-memory port between CPU fetch and a framed
// program loader. A frame is: length byte (0 = 256), payload bytes written
// from LOAD_BASE upward (wrapping), then a checksum byte equal to the
// two's complement of the payload sum. The CPU is held in reset while a
// load is in progress or after a failed load.
// Ports:
//   clock, reset  : system clock, synchronous active-high reset
//   load_req      : one-cycle pulse starting a load (honoured in RUN / ERR)
//   cpu_pc        : CPU fetch address, routed to mem_addr while in RUN
//   cpu_reset     : holds the CPU in reset (LEN, DATA, SUM, ERR)
//   busy          : high in LEN, DATA, SUM
//   done          : one-cycle pulse after a successful load
//   err           : high while in ERR
//   o_dbg_state   : current controller state
//   bus           : byte stream + instruction-memory port (master side)
// Parameters:
//   LOAD_BASE : first address written by a load
//   TIMEOUT   : idle cycles tolerated between bytes, 0 disables the abort
// -----------------------------------------------------------------------------
module imem_boot_loader
   import imem_boot_pkg::*;
#(
   parameter logic [7:0]  LOAD_BASE = 8'h00,
   parameter logic [15:0] TIMEOUT   = 16'd0
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                load_req,
   input  logic [7:0]          cpu_pc,
   output logic                cpu_reset,
   output logic                busy,
   output logic                done,
   output logic                err,
   output boot_state_e         o_dbg_state,
   imem_boot_loader_if.master  bus
);

   boot_state_e r_state;
   boot_state_e w_state_next;

   logic [8:0] r_remaining;
   logic [7:0] r_wr_ptr;
   logic [7:0] r_sum;
   logic [7:0] r_mem_addr;
   logic [7:0] r_mem_w_data;
   logic       r_mem_w_en;
   logic       r_done;

   logic       w_busy;
   logic       w_accept;
   logic       w_sum_ok;
   logic       w_last_data;
   logic       w_expire;

   assign w_busy      = (r_state == ST_LEN) || (r_state == ST_DATA) || (r_state == ST_SUM);
   assign w_accept    = w_busy && bus.rx_valid;
   assign w_sum_ok    = (bus.rx_data == twos_neg8(r_sum));
   assign w_last_data = (r_remaining == 9'd1);

   // Every entry into a busy state happens either on an accepted byte or from
   // RUN/ERR where counting is disabled, so clearing on accept also covers
   // the clear-on-entry behaviour without a combinational loop through
   // the next-state logic.
   imem_boot_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clock    (clock),
      .reset    (reset),
      .i_en     (w_busy),
      .i_clr    (w_accept),
      .o_expire (w_expire)
   );

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state logic. load_req is ignored while a load is in progress.
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_RUN: begin
            if (load_req) begin
               w_state_next = ST_LEN;
            end
         end
         ST_LEN: begin
            if (w_accept) begin
               w_state_next = ST_DATA;
            end else if (w_expire) begin
               w_state_next = ST_ERR;
            end
         end
         ST_DATA: begin
            if (w_accept && w_last_data) begin
               w_state_next = ST_SUM;
            end else if (w_expire) begin
               w_state_next = ST_ERR;
            end
         end
         ST_SUM: begin
            if (w_accept) begin
               w_state_next = w_sum_ok ? ST_RUN : ST_ERR;
            end else if (w_expire) begin
               w_state_next = ST_ERR;
            end
         end
         ST_ERR: begin
            if (load_req) begin
               w_state_next = ST_LEN;
            end
         end
         default: begin
            w_state_next = ST_RUN;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Datapath: length counter, write pointer, running sum, write register.
   // The write strobe is registered, so a payload byte appears on the
   // memory port the cycle after it is accepted; the final payload write
   // therefore lands in the first SUM cycle.
   // ---------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         r_remaining  <= 9'd0;
         r_wr_ptr     <= 8'd0;
         r_sum        <= 8'd0;
         r_mem_addr   <= 8'd0;
         r_mem_w_data <= 8'd0;
         r_mem_w_en   <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_mem_w_en <= 1'b0;
         r_done     <= 1'b0;
         case (r_state)
            ST_LEN: begin
               if (w_accept) begin
                  r_remaining <= frame_len(bus.rx_data);
                  r_wr_ptr    <= LOAD_BASE;
                  r_sum       <= 8'd0;
               end
            end
            ST_DATA: begin
               if (w_accept) begin
                  r_mem_w_en   <= 1'b1;
                  r_mem_w_data <= bus.rx_data;
                  r_mem_addr   <= r_wr_ptr;
                  r_wr_ptr     <= r_wr_ptr + 8'd1;
                  r_sum        <= r_sum + bus.rx_data;
                  r_remaining  <= r_remaining - 9'd1;
               end
            end
            ST_SUM: begin
               if (w_accept && w_sum_ok) begin
                  r_done <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Outputs. In RUN the CPU owns the address bus; elsewhere the address
   // register keeps the last write address.
   // ---------------------------------------------------------------------
   assign bus.rx_ready   = w_busy;
   assign bus.mem_w_en   = r_mem_w_en;
   assign bus.mem_w_data = r_mem_w_data;
   assign bus.mem_addr   = ((r_state == ST_RUN) && !r_mem_w_en) ? cpu_pc : r_mem_addr;

   assign busy        = w_busy;
   assign cpu_reset   = (r_state != ST_RUN);
   assign err         = (r_state == ST_ERR);
   assign done        = r_done;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_imem_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_boot_loader
// Two loaders share one stimulus stream: u_dut0 (LOAD_BASE=00, no timeout)
// and u_dut1 (LOAD_BASE=80, TIMEOUT=10). A frame-level model per instance
// predicts the outputs each cycle; literal checks pin memory contents and
// key timing points.
// -----------------------------------------------------------------------------
module tb_imem_boot_loader;
  import imem_boot_pkg::*;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       tb_reset    = 1'b1;
  logic       tb_load_req = 1'b0;
  logic       tb_rx_valid = 1'b0;
  logic [7:0] tb_rx_data  = 8'h00;
  logic [7:0] tb_cpu_pc   = 8'h05;

  // ---------------------------------------------------------------------------
  // DUTs
  // ---------------------------------------------------------------------------
  imem_boot_loader_if if0 ();
  imem_boot_loader_if if1 ();

  assign if0.rx_valid = tb_rx_valid;
  assign if0.rx_data  = tb_rx_data;
  assign if1.rx_valid = tb_rx_valid;
  assign if1.rx_data  = tb_rx_data;

  logic [1:0]  cpu_reset_w;
  logic [1:0]  busy_w;
  logic [1:0]  done_w;
  logic [1:0]  err_w;
  boot_state_e dbg_state0;
  boot_state_e dbg_state1;

  imem_boot_loader #(.LOAD_BASE(8'h00), .TIMEOUT(16'd0)) u_dut0 (
    .clock       (clock),
    .reset       (tb_reset),
    .load_req    (tb_load_req),
    .cpu_pc      (tb_cpu_pc),
    .cpu_reset   (cpu_reset_w[0]),
    .busy        (busy_w[0]),
    .done        (done_w[0]),
    .err         (err_w[0]),
    .o_dbg_state (dbg_state0),
    .bus         (if0.master)
  );

  imem_boot_loader #(.LOAD_BASE(8'h80), .TIMEOUT(16'd10)) u_dut1 (
    .clock       (clock),
    .reset       (tb_reset),
    .load_req    (tb_load_req),
    .cpu_pc      (tb_cpu_pc),
    .cpu_reset   (cpu_reset_w[1]),
    .busy        (busy_w[1]),
    .done        (done_w[1]),
    .err         (err_w[1]),
    .o_dbg_state (dbg_state1),
    .bus         (if1.master)
  );

  logic [1:0] ready_w;
  logic [1:0] wen_w;
  logic [7:0] addr_w  [2];
  logic [7:0] wdata_w [2];

  assign ready_w[0] = if0.rx_ready;
  assign ready_w[1] = if1.rx_ready;
  assign wen_w[0]   = if0.mem_w_en;
  assign wen_w[1]   = if1.mem_w_en;
  assign addr_w[0]  = if0.mem_addr;
  assign addr_w[1]  = if1.mem_addr;
  assign wdata_w[0] = if0.mem_w_data;
  assign wdata_w[1] = if1.mem_w_data;

  // ---------------------------------------------------------------------------
  // Counters and check helper
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Frame-level model. Phase: 0 fetch, 1 awaiting length, 2 payload,
  // 3 awaiting checksum, 4 failed.
  // ---------------------------------------------------------------------------
  localparam int P_FETCH = 0;
  localparam int P_LEN   = 1;
  localparam int P_PAY   = 2;
  localparam int P_CSUM  = 3;
  localparam int P_FAIL  = 4;

  int base_of [2] = '{0, 128};
  int tmo_of  [2] = '{0, 10};

  int         m_phase [2];
  int         m_left  [2];
  int         m_ptr   [2];
  int         m_sum   [2];
  int         m_idle  [2];
  logic       e_done  [2];
  logic       e_wen   [2];
  logic [7:0] e_wdata [2];
  logic [7:0] e_waddr [2];
  logic       started = 1'b0;

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_phase[k] = P_FETCH; m_left[k] = 0; m_ptr[k] = 0; m_sum[k] = 0; m_idle[k] = 0;
      e_done[k] = 1'b0; e_wen[k] = 1'b0; e_wdata[k] = 8'h00; e_waddr[k] = 8'h00;
    end
  end

  function automatic logic in_load(input int ph);
    return (ph == P_LEN) || (ph == P_PAY) || (ph == P_CSUM);
  endfunction

  always @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (tb_reset) begin
        m_phase[k] = P_FETCH; m_idle[k] = 0;
        e_done[k] = 1'b0; e_wen[k] = 1'b0; e_wdata[k] = 8'h00;
      end else begin
        int  prev;
        logic took;
        int  b;
        prev = m_phase[k];
        took = in_load(prev) && tb_rx_valid;
        b    = int'(tb_rx_data);
        e_done[k] = 1'b0;
        e_wen[k]  = 1'b0;
        if ((prev == P_FETCH || prev == P_FAIL) && tb_load_req) m_phase[k] = P_LEN;
        if (took) begin
          if (prev == P_LEN) begin
            m_left[k]  = (b == 0) ? 256 : b;
            m_ptr[k]   = base_of[k];
            m_sum[k]   = 0;
            m_phase[k] = P_PAY;
          end else if (prev == P_PAY) begin
            e_wen[k]   = 1'b1;
            e_wdata[k] = tb_rx_data;
            e_waddr[k] = 8'(m_ptr[k]);
            m_ptr[k]   = (m_ptr[k] + 1) % 256;
            m_sum[k]   = (m_sum[k] + b) % 256;
            m_left[k]  = m_left[k] - 1;
            if (m_left[k] == 0) m_phase[k] = P_CSUM;
          end else begin
            // Good frame: payload sum plus trailer is a multiple of 256.
            if ((m_sum[k] + b) % 256 == 0) begin
              e_done[k]  = 1'b1;
              m_phase[k] = P_FETCH;
            end else begin
              m_phase[k] = P_FAIL;
            end
          end
        end
        if (in_load(prev) && !took && tmo_of[k] != 0) begin
          m_idle[k]++;
          if (m_idle[k] == tmo_of[k]) begin
            m_phase[k] = P_FAIL;
            m_idle[k]  = 0;
          end
        end else begin
          m_idle[k] = 0;
        end
      end
    end
    if (tb_reset) started = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Scoreboard: per-cycle compare plus captured memory image
  // ---------------------------------------------------------------------------
  logic [7:0] img [2][256];
  int         n_wr     [2] = '{0, 0};
  int         done_cnt [2] = '{0, 0};

  always @(posedge clock) begin
    #2;
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        logic ld;
        ld = in_load(m_phase[k]);
        check($sformatf("d%0d_busy", k),      32'(busy_w[k]),      32'(ld));
        check($sformatf("d%0d_rx_ready", k),  32'(ready_w[k]),     32'(ld));
        check($sformatf("d%0d_cpu_reset", k), 32'(cpu_reset_w[k]), 32'(m_phase[k] != P_FETCH));
        check($sformatf("d%0d_err", k),       32'(err_w[k]),       32'(m_phase[k] == P_FAIL));
        check($sformatf("d%0d_done", k),      32'(done_w[k]),      32'(e_done[k]));
        check($sformatf("d%0d_w_en", k),      32'(wen_w[k]),       32'(e_wen[k]));
        check($sformatf("d%0d_w_data", k),    32'(wdata_w[k]),     32'(e_wdata[k]));
        if (e_wen[k]) begin
          check($sformatf("d%0d_w_addr", k), 32'(addr_w[k]), 32'(e_waddr[k]));
        end else if (m_phase[k] == P_FETCH) begin
          check($sformatf("d%0d_fetch_addr", k), 32'(addr_w[k]), 32'(tb_cpu_pc));
        end
        if (wen_w[k]) begin
          img[k][addr_w[k]] = wdata_w[k];
          n_wr[k]++;
        end
        if (done_w[k]) done_cnt[k]++;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  logic [7:0] tx_q [$];

  task automatic pulse_load_req();
    @(negedge clock);
    tb_load_req = 1'b1;
    @(negedge clock);
    tb_load_req = 1'b0;
  endtask

  // Sends tx_q; gap idle cycles after each byte; load_req raised with byte lr_at.
  task automatic send_q(input int gap, input int lr_at);
    for (int i = 0; i < tx_q.size(); i++) begin
      @(negedge clock);
      tb_rx_valid = 1'b1;
      tb_rx_data  = tx_q[i];
      tb_load_req = (i == lr_at);
      for (int g = 0; g < gap; g++) begin
        @(negedge clock);
        tb_rx_valid = 1'b0;
        tb_load_req = 1'b0;
      end
    end
    @(negedge clock);
    tb_rx_valid = 1'b0;
    tb_load_req = 1'b0;
    tx_q.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    repeat (3) @(negedge clock);
    tb_reset = 1'b0;
    @(negedge clock);
    check("reset_cpu_reset", 32'(cpu_reset_w), 32'h0);
    check("reset_rx_ready",  32'(ready_w),     32'h0);
    check("reset_w_en",      32'(wen_w),       32'h0);
    check("reset_w_data",    32'(wdata_w[0]),  32'h00);
    check("reset_err",       32'(err_w),       32'h0);

    // Normal load
    pulse_load_req();
    tx_q = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h9A};
    send_q(0, -1);
    check("normal_done",      32'(done_w),      32'h3);
    check("normal_cpu_reset", 32'(cpu_reset_w), 32'h0);
    check("normal_img0_0",    32'(img[0][0]),   32'h11);
    check("normal_img0_1",    32'(img[0][1]),   32'h22);
    check("normal_img0_2",    32'(img[0][2]),   32'h33);
    check("normal_img1_82",   32'(img[1][8'h82]), 32'h33);
    @(negedge clock);
    check("normal_done_end",  32'(done_w),      32'h0);
    check("normal_fetch_pc",  32'(addr_w[0]),   32'h05);

    // Bad checksum, then recovery
    pulse_load_req();
    tx_q = '{8'h01, 8'hAA, 8'h00};
    send_q(0, -1);
    check("bad_err",       32'(err_w),       32'h3);
    check("bad_cpu_reset", 32'(cpu_reset_w), 32'h3);
    check("bad_rx_ready",  32'(ready_w),     32'h0);
    repeat (2) @(negedge clock);
    pulse_load_req();
    tx_q = '{8'h02, 8'h01, 8'h02, 8'hFD};
    send_q(0, -1);
    check("recover_done", 32'(done_w), 32'h3);
    check("recover_err",  32'(err_w),  32'h0);
    check("recover_img0", 32'(img[0][1]), 32'h02);

    // Length 0 = 256 bytes 00..FF, checksum 80
    pulse_load_req();
    tx_q.push_back(8'h00);
    for (int i = 0; i < 256; i++) tx_q.push_back(8'(i));
    tx_q.push_back(8'h80);
    send_q(0, -1);
    check("len0_done",     32'(done_w),          32'h3);
    check("len0_img1_80",  32'(img[1][8'h80]),   32'h00);
    check("len0_img1_ff",  32'(img[1][8'hFF]),   32'h7F);
    check("len0_img1_00",  32'(img[1][8'h00]),   32'h80);
    check("len0_img1_7f",  32'(img[1][8'h7F]),   32'hFF);
    check("len0_img0_ff",  32'(img[0][8'hFF]),   32'hFF);

    // Throttled stream with an ignored mid-payload load_req
    pulse_load_req();
    tx_q = '{8'h04, 8'h10, 8'h20, 8'h30, 8'h40, 8'h60};
    send_q(1, 2);
    check("thr_done_cnt0", 32'(done_cnt[0]), 32'd4);
    check("thr_done_cnt1", 32'(done_cnt[1]), 32'd4);
    check("thr_n_wr0",     32'(n_wr[0]),     32'd266);
    check("thr_n_wr1",     32'(n_wr[1]),     32'd266);
    check("thr_img0_3",    32'(img[0][3]),   32'h40);
    check("thr_img1_81",   32'(img[1][8'h81]), 32'h20);
    tb_cpu_pc = 8'h3C;
    @(negedge clock);
    check("thr_fetch_pc",  32'(addr_w[0]),   32'h3C);

    // Timeout after the length byte (only u_dut1 has one)
    pulse_load_req();
    tx_q = '{8'h03};
    send_q(0, -1);
    repeat (9) @(negedge clock);
    check("tmo_busy_c10", 32'(busy_w), 32'h3);
    @(negedge clock);
    check("tmo_err_c11",  32'(err_w),  32'h2);
    check("tmo_busy_c11", 32'(busy_w), 32'h1);
    check("tmo_no_wr",    32'(n_wr[1]), 32'd266);

    // Reset in the middle of a payload write
    @(negedge clock);
    tb_reset = 1'b1;
    repeat (2) @(negedge clock);
    tb_reset = 1'b0;
    pulse_load_req();
    tx_q = '{8'h04, 8'hAA, 8'hBB};
    send_q(0, -1);
    check("rst_wr_pending", 32'(wen_w), 32'h3);
    tb_reset = 1'b1;
    @(negedge clock);
    tb_reset = 1'b0;
    check("rst_cpu_reset", 32'(cpu_reset_w), 32'h0);
    check("rst_w_en",      32'(wen_w),       32'h0);
    check("rst_err",       32'(err_w),       32'h0);
    check("rst_busy",      32'(busy_w),      32'h0);
    check("rst_n_wr0",     32'(n_wr[0]),     32'd268);
    check("rst_img0_1",    32'(img[0][1]),   32'hBB);

    repeat (3) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
